// File: rtl/cla_byte_serial_adder.sv
// Byte-serial multi-byte adder around one shared 8-bit CLA stage.
// Ports: clk, rst_n, start/A/B/C_in in; busy, done, S, C_out, V out.
module cla_byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] A,
  input  logic [8*NBYTES-1:0] B,
  input  logic                C_in,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] S,
  output logic                C_out,
  output logic                V
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  typedef enum logic {
    IDLE,
    ADD
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [KW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   s_q, s_d;
  logic           co_q, co_d;
  logic           v_q, v_d;
  logic           done_q, done_d;

  logic [7:0]     a_byte;
  logic [7:0]     b_byte;
  logic [7:0]     cla_s;
  logic           cla_co;

  assign a_byte = a_q[8*k_q +: 8];
  assign b_byte = b_q[8*k_q +: 8];

  CLA_8bit u_cla (
    .A     (a_byte),
    .B     (b_byte),
    .C     (carry_q),
    .C_out (cla_co),
    .S     (cla_s)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    v_d     = v_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = C_in;
          k_d     = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[8*k_q +: 8] = cla_s;
        carry_d = cla_co;
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          // sum_d already holds the final byte here
          s_d     = sum_d;
          co_d    = cla_co;
          v_d     = (a_q[W-1] == b_q[W-1]) &&
                    (sum_d[W-1] != a_q[W-1]);
          done_d  = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == ADD);
  assign done  = done_q;
  assign S     = s_q;
  assign C_out = co_q;
  assign V     = v_q;

endmodule

// 8-bit carry-lookahead adder stage.
// Ports: A, B, C (carry in) in; C_out, S out.
module CLA_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C,
  output logic       C_out,
  output logic [7:0] S
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Each carry is a flat sum of products of g/p/C,
  // so no carry depends on the previous carry signal.
  always_comb begin
    logic cy;
    logic pp;
    c    = '0;
    c[0] = C;
    for (int i = 0; i < 8; i++) begin
      cy = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cy = cy | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cy | (pp & C);
    end
  end

  assign S     = p ^ c[7:0];
  assign C_out = c[8];

endmodule

// File: tb/tb_cla_byte_serial_adder.sv
// Self-checking bench for cla_byte_serial_adder.
// Random and directed adds against an arithmetic model.
module tb_cla_byte_serial_adder;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
  logic         v;

  int checks;
  int failures;

  cla_byte_serial_adder #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .C_in  (c_in),
    .busy  (busy),
    .done  (done),
    .S     (s),
    .C_out (c_out),
    .V     (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci);
    longint       us;
    longint       ss;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    us  = longint'({32'd0, x}) + longint'({32'd0, y}) + longint'(ci);
    ss  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    sum = us[W-1:0];
    co  = us[W];
    ov  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return {ov, co, sum};
  endfunction

  task automatic do_add(input string tag,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic ci);
    logic [W+1:0] e;
    int  n;
    bit  busy_ok;
    e = model(x, y, ci);
    @(negedge clk);
    a = x; b = y; c_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    check({tag, ".busy"}, 64'(busy), 64'd1);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 4 * NBYTES) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".lat"}, 64'(n), 64'(NBYTES));
    check({tag, ".busyheld"}, 64'(busy_ok), 64'd1);
    check({tag, ".S"}, 64'(s), 64'(e[W-1:0]));
    check({tag, ".Cout"}, 64'(c_out), 64'(e[W]));
    check({tag, ".V"}, 64'(v), 64'(e[W+1]));
    @(posedge clk); #1;
    check({tag, ".donepulse"}, 64'(done), 64'd0);
    check({tag, ".Shold"}, 64'(s), 64'(e[W-1:0]));
  endtask

  initial begin
    int           dcount;
    logic [W-1:0] s_seen;
    int           t1, t2, cyc;
    logic [W-1:0] s1, s2;
    logic [W-1:0] rx, ry;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; c_in = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.S", 64'(s), 64'd0);
    check("rst.Cout", 64'(c_out), 64'd0);
    check("rst.V", 64'(v), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_add("ff_p1", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    do_add("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    do_add("ovpos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_add("ovneg", 32'h8000_0000, 32'h8000_0000, 1'b0);

    // start pulsed while busy must be ignored
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    s_seen = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin
        a = 32'hFFFF_FFFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dcount++;
        s_seen = s;
      end
    end
    check("midop.dones", 64'(dcount), 64'd1);
    check("midop.S", 64'(s_seen), 64'h2345_6789);
    check("midop.idle", 64'(busy), 64'd0);

    // reset in the middle of an add
    do_add("one_one", 32'h1, 32'h1, 1'b0);
    @(negedge clk);
    a = 32'h0000_FFFF; b = 32'h1; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.S", 64'(s), 64'd0);
    check("rstmid.Cout", 64'(c_out), 64'd0);
    check("rstmid.V", 64'(v), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("rstmid.nodone", 64'(dcount), 64'd0);
    check("rstmid.Shold", 64'(s), 64'd0);
    do_add("after_rst", 32'h0000_FFFF, 32'h1, 1'b0);

    // start held high: back-to-back accepts
    @(negedge clk);
    a = 32'd15; b = 32'd84; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd212; b = 32'h0000_00AA;
    t1 = -1; t2 = -1; s1 = '0; s2 = '0;
    cyc = 0;
    while (t2 < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc; s1 = s;
        end else begin
          t2 = cyc; s2 = s;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b.gap", 64'(t2 - t1), 64'd5);
    check("b2b.S1", 64'(s1), 64'h63);
    check("b2b.S2", 64'(s2), 64'h17E);
    repeat (2) @(posedge clk);
    #1;
    check("b2b.idle", 64'(busy), 64'd0);

    for (int i = 0; i < 25; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      if (i % 5 == 0) ry = ~rx;
      if (i % 7 == 0) rx[W-1] = ry[W-1];
      do_add("rand", rx, ry, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
